shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter XLEN, default 16, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port resetn_i, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port in_valid_i, input, 1, indicating that the operands are presented.
REQ-005 The block SHALL have port in_ready_o, output, 1, indicating that the block can accept operands.
REQ-006 The block SHALL have port signed_i, input, 1, where 1 treats a_i and b_i as two's complement and 0 treats them as unsigned; it is sampled with the operands.
REQ-007 The block SHALL have port a_i, input, XLEN, the multiplicand.
REQ-008 The block SHALL have port b_i, input, XLEN, the multiplier.
REQ-009 The block SHALL have port out_valid_o, output, 1, indicating that product_o is valid.
REQ-010 The block SHALL have port out_ready_i, input, 1, indicating that the consumer accepts the product.
REQ-011 The block SHALL have port product_o, output, 2*XLEN, the full-width product.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-013 The block SHALL drive in_ready_o high only in IDLE, decoded from state.
REQ-014 The block SHALL drive out_valid_o high only in DONE, decoded from state.
REQ-015 The block SHALL perform input acceptance when in_valid_i and in_ready_o are both high on a rising edge, with the following actions.
- Latch the magnitudes of a_i and b_i, zero the accumulator, and latch neg = signed_i & (a_i[MSB] ^ b_i[MSB]).
- Transition to CALC, or directly to DONE if |b_i| == 0.
REQ-016 The block SHALL take magnitudes as the raw value when signed_i=0, and as the two's-complement absolute value in XLEN unsigned bits when signed_i=1; -2^(XLEN-1) maps to 2^(XLEN-1) without overflow.
REQ-017 The block SHALL perform the following in each CALC cycle.
- Add the 2*XLEN-bit shifted multiplicand to the accumulator if multiplier bit 0 is 1.
- Shift the multiplicand left by 1 and the multiplier right by 1.
- Go to DONE when the shifted multiplier is 0.
REQ-018 The block SHALL have a latency from acceptance edge to out_valid_o high of 1 + bitlength(|b|) cycles: minimum 1 (b=0), maximum XLEN+1.
REQ-019 The block SHALL drive product_o = neg ? -acc : acc, modulo 2^(2*XLEN), from registers only; it is don't-care outside DONE but never X after reset.
REQ-020 The block SHALL hold product_o and out_valid_o stable in DONE while out_ready_i is low, under unbounded backpressure.
REQ-021 The block SHALL go from DONE to IDLE on the edge where out_ready_i is high; in_ready_o is high the following cycle, so there is no same-cycle accept in DONE.
REQ-022 The block SHALL ignore in_valid_i, a_i, b_i and signed_i outside IDLE; it SHALL NOT corrupt an in-flight operation.
REQ-023 The block SHALL ignore out_ready_i outside DONE.

Reset
REQ-024 The block SHALL, when resetn_i is low at a rising edge, return the state to IDLE and clear the accumulator, operand registers and neg to 0.
- This applies regardless of the current state, including mid-CALC and DONE.
- It gives in_ready_o=1, out_valid_o=0 and product_o=0 from the first edge of reset.
REQ-025 The block SHALL discard any operation interrupted by reset, emitting no product for it.

Structure
REQ-026 The block SHALL take the FSM state enum type (IDLE, CALC, DONE) from the shared package mult_pkg, which other multiplier variants also use.
REQ-027 The block SHALL separate control from datapath via a single sub-module, shift_add_mult_ctrl (FSM and handshake decode), with the accumulator and shifters in the top level.

Verification (XLEN=16)
REQ-028 The bench SHALL cover unsigned 3 x 5: signed_i=0, a=0x0003, b=0x0005 -> product_o=0x0000000F, with out_valid_o 4 cycles after acceptance.
REQ-029 The bench SHALL cover signed -3 x 5: signed_i=1, a=0xFFFD, b=0x0005 -> product_o=0xFFFFFFF1, with latency 4.
REQ-030 The bench SHALL cover the signed most-negative boundary: a=b=0x8000, signed_i=1 -> product_o=0x40000000, with latency 17; the same operands unsigned -> 0x40000000, with latency 17.
REQ-031 The bench SHALL cover a zero multiplier: a=0xFFFF, b=0x0000, signed_i=1 -> product_o=0x00000000, with latency 1; the unsigned case 0xFFFF x 0xFFFF -> 0xFFFE0001.
REQ-032 The bench SHALL cover backpressure: out_ready_i held low 6 cycles in DONE -> product_o and out_valid_o stable and in_ready_o low; out_ready_i high -> IDLE, and in_ready_o high on the next cycle.
REQ-033 The bench SHALL cover reset mid-CALC: resetn_i low for 1 cycle during CALC of 0x1234 x 0x00FF -> IDLE, outputs at reset values, no out_valid_o pulse; a next op 7 x 9 -> 0x0000003F.

Source files
------------

// File: rtl/mult_pkg.sv
// Types shared by the sequential multiplier variants.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the shift-add multiplier: state and handshake decode.
module shift_add_mult_ctrl
  import mult_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic in_valid,
  input  logic out_ready,
  input  logic zero_b,
  input  logic last,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic calc
);

  mult_state_t state_q;
  mult_state_t state_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    calc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = zero_b ? DONE : CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, signed or unsigned operands.
// Works on magnitudes and applies the sign once at the end.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*XLEN-1:0] product_o
);

  localparam int PW = 2 * XLEN;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] mplier_q;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   prod_q;
  logic            neg_q;
  logic            accept;
  logic            calc;
  logic            zero_b;
  logic            last;

  // -2^(XLEN-1) negates to itself, which is the right unsigned magnitude
  assign mag_a = (signed_i & a_i[XLEN-1]) ? -a_i : a_i;
  assign mag_b = (signed_i & b_i[XLEN-1]) ? -b_i : b_i;

  assign zero_b = (b_i == '0);
  assign last   = (mplier_q[XLEN-1:1] == '0);
  assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;

  shift_add_mult_ctrl u_ctrl (
    .clk       (clk_i),
    .resetn    (resetn_i),
    .in_valid  (in_valid_i),
    .out_ready (out_ready_i),
    .zero_b    (zero_b),
    .last      (last),
    .in_ready  (in_ready_o),
    .out_valid (out_valid_o),
    .accept    (accept),
    .calc      (calc)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else if (accept) begin
      mcand_q  <= {{XLEN{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
      neg_q    <= signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
      prod_q   <= '0;
    end else if (calc) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        prod_q <= neg_q ? -acc_d : acc_d;
      end
    end
  end

  assign product_o = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: arithmetic reference model,
// per-cycle output compare, directed corner cases, random traffic.
module tb_shift_add_mult;

  localparam int W = 16;

  logic           clk_i = 1'b0;
  logic           resetn_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic           signed_i = 1'b0;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [2*W-1:0] product_o;

  always #5 clk_i = ~clk_i;

  shift_add_mult #(.XLEN(W)) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model_prod(
    input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  function automatic int model_lat(
    input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int n;
    m = (s && b[W-1]) ? -b : b;
    n = 0;
    while (m != '0) begin
      n++;
      m = m >> 1;
    end
    return 1 + n;
  endfunction

  // Model: one op in flight, visible from its done edge
  bit             pending = 1'b0;
  bit             last_rst = 1'b0;
  bit             chk_en = 1'b0;
  longint         nedges = 0;
  longint         done_edge = 0;
  longint         acc_edge = 0;
  logic [2*W-1:0] exp_prod = '0;
  int             acc_cnt = 0;

  always @(posedge clk_i) begin
    if (!resetn_i) begin
      pending  = 1'b0;
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (pending && nedges >= done_edge) begin
        if (out_ready_i) pending = 1'b0;
      end else if (!pending && in_valid_i) begin
        pending   = 1'b1;
        acc_edge  = nedges + 1;
        done_edge = nedges + model_lat(signed_i, b_i);
        exp_prod  = model_prod(signed_i, a_i, b_i);
        acc_cnt++;
      end
    end
    nedges++;
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("in_ready", in_ready_o, !pending);
      chk("out_valid", out_valid_o,
          pending && nedges >= done_edge);
      if (pending && nedges >= done_edge)
        chk("product", product_o, exp_prod);
      if (last_rst)
        chk("rst_product", product_o, '0);
    end
  end

  task automatic wait_accept(input int start);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (acc_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", ok, 1'b1);
    in_valid_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    signed_i = 1'($urandom);
  endtask

  task automatic directed(input logic s,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [2*W-1:0] ep,
                          input int el,
                          input int hold);
    bit got;
    int start;
    chk("model_prod", model_prod(s, a, b), ep);
    chk("model_lat", model_lat(s, b), el);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    signed_i = s;
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    start = acc_cnt;
    wait_accept(start);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("done_seen", got, 1'b1);
    chk("latency", 64'(nedges - acc_edge + 1), 64'(el));
    chk("lit_product", product_o, ep);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      chk("bp_valid", out_valid_o, 1'b1);
      chk("bp_product", product_o, ep);
      chk("bp_in_ready", in_ready_o, 1'b0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("drain_valid", out_valid_o, 1'b0);
    chk("drain_in_ready", in_ready_o, 1'b1);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'h8000;
      2: return W'($urandom_range(1, 15));
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int start;
    int ops;
    int cyc;
    int last;
    bit idle;
    resetn_i = 1'b0;
    @(negedge clk_i);
    chk_en = 1'b1;
    @(negedge clk_i);
    resetn_i = 1'b1;

    directed(1'b0, 16'h0003, 16'h0005, 32'h0000000F, 4, 0);
    directed(1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 4, 0);
    directed(1'b1, 16'h8000, 16'h8000, 32'h40000000, 17, 0);
    directed(1'b0, 16'h8000, 16'h8000, 32'h40000000, 17, 0);
    directed(1'b1, 16'hFFFF, 16'h0000, 32'h00000000, 1, 0);
    directed(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, 0);
    directed(1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 4, 6);

    // Reset in the middle of a long calculation
    @(negedge clk_i);
    out_ready_i = 1'b0;
    signed_i = 1'b0;
    a_i = 16'h1234;
    b_i = 16'h00FF;
    in_valid_i = 1'b1;
    start = acc_cnt;
    wait_accept(start);
    repeat (3) @(negedge clk_i);
    resetn_i = 1'b0;
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_prod", product_o, '0);
    resetn_i = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      chk("no_stale_valid", out_valid_o, 1'b0);
    end
    directed(1'b0, 16'h0007, 16'h0009, 32'h0000003F, 5, 0);

    // Random traffic with random backpressure
    ops = 0;
    cyc = 0;
    last = acc_cnt;
    in_valid_i = 1'b0;
    while (ops < 300 && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      out_ready_i = ($urandom_range(0, 3) != 0);
      if (in_valid_i && acc_cnt != last) begin
        in_valid_i = 1'b0;
        ops++;
      end
      last = acc_cnt;
      if (!in_valid_i) begin
        a_i = rnd_op();
        b_i = rnd_op();
        signed_i = 1'($urandom);
        in_valid_i = ($urandom_range(0, 2) != 0);
      end
    end
    chk("random_ops", ops, 300);

    @(negedge clk_i);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    idle = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (!pending) begin
        idle = 1'b1;
        break;
      end
    end
    chk("final_idle", idle, 1'b1);
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
